// File: rtl/im_loader_if.sv
// Byte-stream input and IM write-port signals of the instruction-memory loader.
// The slave view belongs to the loader; the master view belongs to the host/link side.
interface im_loader_if #(
    parameter int WIDTH_IM_ADDR = 32
);
    logic                     byte_valid;
    logic [7:0]               byte_data;
    logic                     byte_last;
    logic                     byte_ready;
    logic                     im_we;
    logic [WIDTH_IM_ADDR-1:0] im_waddr;
    logic [31:0]              im_wdata;

    modport master (
        output byte_valid, byte_data, byte_last,
        input  byte_ready, im_we, im_waddr, im_wdata
    );

    modport slave (
        input  byte_valid, byte_data, byte_last,
        output byte_ready, im_we, im_waddr, im_wdata
    );
endinterface

// File: rtl/im_loader.sv
// Boot-time instruction-memory writer: packs a handshaked byte stream into 32-bit words
// and writes them to consecutive IM addresses starting at PC_INIT.
module im_loader #(
    parameter int                       IM_DEPTH      = 2048,
    parameter int                       WIDTH_IM_ADDR = 32,
    parameter logic [WIDTH_IM_ADDR-1:0] PC_INIT       = '0,
    parameter bit                       BYTE_SWAP     = 1'b1,
    localparam int                      WC_W          = $clog2(IM_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    im_loader_if.slave      bus,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_partial_o,
    output logic            err_overflow_o,
    output logic [WC_W-1:0] word_count_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t                   state_q, state_d;
    logic [1:0]               byte_cnt_q;
    logic                     last_q;
    logic [WC_W-1:0]          word_count_q;
    logic [WIDTH_IM_ADDR-1:0] waddr_q;
    logic [31:0]              wdata_q;
    logic                     done_q, err_partial_q, err_overflow_q;

    logic                     in_recv;
    logic                     xfer;
    logic                     at_capacity;
    logic                     start_ok;
    logic                     store;
    logic [31:0]              packed_word;

    assign in_recv     = (state_q == S_RECV);
    assign xfer        = in_recv && bus.byte_valid;
    assign at_capacity = (word_count_q == WC_W'(IM_DEPTH));
    assign start_ok    = start_i && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
    // An overflowing byte is rejected by the error path and never lands in a lane.
    assign store       = xfer && !at_capacity;

    // Lanes 0..2 hold the first three bytes; the fourth is taken straight off the bus.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] lane_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lane_q <= '0;
                end else if (start_ok) begin
                    lane_q <= '0;
                end else if (store && byte_cnt_q == 2'(gi)) begin
                    lane_q <= bus.byte_data;
                end
            end
        end
    endgenerate

    assign packed_word = BYTE_SWAP
        ? {bus.byte_data, g_lane[2].lane_q, g_lane[1].lane_q, g_lane[0].lane_q}
        : {g_lane[0].lane_q, g_lane[1].lane_q, g_lane[2].lane_q, bus.byte_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) state_d = S_RECV;
            end
            S_RECV: begin
                if (xfer) begin
                    if (at_capacity)               state_d = S_ERR;
                    else if (byte_cnt_q == 2'd3)   state_d = S_WRITE;
                    else if (bus.byte_last)        state_d = S_ERR;
                end
            end
            S_WRITE: begin
                state_d = last_q ? S_DONE : S_RECV;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.byte_ready = in_recv;
        bus.im_we      = (state_q == S_WRITE);
        busy_o         = in_recv || (state_q == S_WRITE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q     <= '0;
            last_q         <= 1'b0;
            word_count_q   <= '0;
            waddr_q        <= '0;
            wdata_q        <= '0;
            done_q         <= 1'b0;
            err_partial_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else if (start_ok) begin
            byte_cnt_q     <= '0;
            last_q         <= 1'b0;
            word_count_q   <= '0;
            done_q         <= 1'b0;
            err_partial_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else if (xfer) begin
            if (at_capacity) begin
                err_overflow_q <= 1'b1;
            end else begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                if (byte_cnt_q == 2'd3) begin
                    // Address and data are captured here so they stay put for the whole write cycle.
                    waddr_q <= PC_INIT + (WIDTH_IM_ADDR'(word_count_q) << 2);
                    wdata_q <= packed_word;
                    last_q  <= bus.byte_last;
                end else if (bus.byte_last) begin
                    err_partial_q <= 1'b1;
                end
            end
        end else if (state_q == S_WRITE) begin
            word_count_q <= word_count_q + WC_W'(1);
            if (last_q) done_q <= 1'b1;
        end
    end

    assign bus.im_waddr   = waddr_q;
    assign bus.im_wdata   = wdata_q;
    assign done_o         = done_q;
    assign err_partial_o  = err_partial_q;
    assign err_overflow_o = err_overflow_q;
    assign word_count_o   = word_count_q;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: directed sessions plus randomized images, each
// compared against a word-level reference model of the expected IM writes and flags.
module tb_im_loader;
    localparam int          DEPTH = 4;
    localparam int          AW    = 32;
    localparam logic [31:0] PC    = 32'h0000_0000;
    localparam int          WC_W  = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            busy, done, errp, erro;
    logic [WC_W-1:0] wc;

    always #5 clk = ~clk;

    im_loader_if #(.WIDTH_IM_ADDR(AW)) bus ();

    im_loader #(
        .IM_DEPTH     (DEPTH),
        .WIDTH_IM_ADDR(AW),
        .PC_INIT      (PC),
        .BYTE_SWAP    (1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start),
        .bus           (bus),
        .busy_o        (busy),
        .done_o        (done),
        .err_partial_o (errp),
        .err_overflow_o(erro),
        .word_count_o  (wc)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          c;
    } wr_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   ready_viol = 0;
    int   flag_viol  = 0;
    wr_t  got_q[$];
    wr_t  exp_q[$];
    logic [7:0] stim_q[$];
    int   last_idx;
    logic exp_done, exp_p, exp_o;
    int   exp_wc;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the IM write port mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (bus.im_we) got_q.push_back('{bus.im_waddr, bus.im_wdata, cyc});
        if (bus.im_we && bus.byte_ready) ready_viol <= ready_viol + 1;
        if (int'(done) + int'(errp) + int'(erro) > 1) flag_viol <= flag_viol + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: how many whole words land in IM and which sticky flag ends the session.
    function automatic void model();
        int n = stim_q.size();
        exp_q.delete();
        exp_done = 1'b0; exp_p = 1'b0; exp_o = 1'b0;
        if (n > 4 * DEPTH) begin
            exp_o  = 1'b1;
            exp_wc = DEPTH;
        end else begin
            exp_wc = n / 4;
            if (n % 4 == 0) exp_done = 1'b1;
            else            exp_p    = 1'b1;
        end
        for (int w = 0; w < exp_wc; w++)
            exp_q.push_back('{PC + 32'(4 * w),
                              {stim_q[4*w+3], stim_q[4*w+2], stim_q[4*w+1], stim_q[4*w]}, 0});
    endfunction

    // Runs one load session from stim_q; returns the cycle stamp of the start edge.
    task automatic run_session(input bit gaps, input int start_mid_at, input int abort_after,
                               output int e_cyc);
        logic rdy;
        int   waited;
        got_q.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e_cyc = cyc;
        for (int i = 0; i < stim_q.size(); i++) begin
            if (i == abort_after) break;
            if (gaps) begin
                int idle = $urandom_range(0, 2);
                bus.byte_valid = 1'b0;
                repeat (idle) begin @(posedge clk); #1; end
            end
            if (i == start_mid_at) start = 1'b1;
            bus.byte_valid = 1'b1;
            bus.byte_data  = stim_q[i];
            bus.byte_last  = (i == last_idx);
            waited = 0;
            do begin
                @(negedge clk);
                rdy = bus.byte_ready;
                @(posedge clk); #1;
                start = 1'b0;
                waited++;
            end while (!rdy && waited < 50);
            if (!rdy) begin
                check("xfer_timeout", 64'(rdy), 64'd1);
                break;
            end
        end
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
        bus.byte_data  = $urandom_range(0, 255);
        if (abort_after < 0) begin
            waited = 0;
            while (busy && waited < 40) begin @(posedge clk); #1; waited++; end
            check("session_busy_end", 64'(busy), 64'd0);
            repeat (2) begin @(posedge clk); #1; end
        end
    endtask

    task automatic compare_session(input string tag);
        model();
        check({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                check({tag, "_addr"}, 64'(got_q[i].addr), 64'(exp_q[i].addr));
                check({tag, "_data"}, 64'(got_q[i].data), 64'(exp_q[i].data));
            end
        end
        check({tag, "_done"}, 64'(done), 64'(exp_done));
        check({tag, "_errp"}, 64'(errp), 64'(exp_p));
        check({tag, "_erro"}, 64'(erro), 64'(exp_o));
        check({tag, "_wc"},   64'(wc),   64'(exp_wc));
        $display("session %s: bytes=%0d last=%0d writes=%0d done=%0b errp=%0b erro=%0b wc=%0d",
                 tag, stim_q.size(), last_idx, got_q.size(), done, errp, erro, wc);
    endtask

    initial begin
        int e_cyc;
        int l, n;
        logic [31:0] w0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        bus.byte_last  = 1'b0;

        // Reset values, with start held high while in reset.
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_ready", 64'(bus.byte_ready), 64'd0);
        check("rst_we",    64'(bus.im_we), 64'd0);
        check("rst_waddr", 64'(bus.im_waddr), 64'd0);
        check("rst_wdata", 64'(bus.im_wdata), 64'd0);
        check("rst_flags", 64'({done, errp, erro}), 64'd0);
        check("rst_wc",    64'(wc), 64'd0);
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", 64'(busy), 64'd0);

        // Single word, fixed bytes.
        stim_q = '{8'h24, 8'h08, 8'h00, 8'h05};
        last_idx = 3;
        run_session(1'b0, -1, -1, e_cyc);
        compare_session("single");
        w0 = (got_q.size() > 0) ? got_q[0].data : 32'hDEAD_BEEF;
        check("single_word_const", 64'(w0), 64'h0500_0824);

        // Back-to-back 3-word stream started from DONE: writes every 5 cycles from PC_INIT.
        stim_q.delete();
        for (int i = 0; i < 12; i++) stim_q.push_back(8'($urandom_range(0, 255)));
        last_idx = 11;
        run_session(1'b0, -1, -1, e_cyc);
        compare_session("stream");
        for (int i = 0; i < 3; i++)
            if (i < got_q.size()) check("stream_we_cycle", 64'(got_q[i].c - e_cyc), 64'(4 + 5 * i));

        // Partial image: last on 6th byte.
        stim_q.delete();
        for (int i = 0; i < 6; i++) stim_q.push_back(8'($urandom_range(0, 255)));
        last_idx = 5;
        run_session(1'b1, -1, -1, e_cyc);
        compare_session("partial");

        // Overflow: 17 bytes, no last.
        stim_q.delete();
        for (int i = 0; i < 17; i++) stim_q.push_back(8'($urandom_range(0, 255)));
        last_idx = -1;
        run_session(1'b1, -1, -1, e_cyc);
        compare_session("overflow");

        // Reset after 2 bytes of word 2: only word 1 was written.
        stim_q.delete();
        for (int i = 0; i < 8; i++) stim_q.push_back(8'($urandom_range(0, 255)));
        last_idx = 7;
        run_session(1'b0, -1, 6, e_cyc);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_we",   64'(bus.im_we), 64'd0);
        check("midrst_wc",   64'(wc), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("midrst_nwrites", 64'(got_q.size()), 64'd1);
        check("midrst_idle",    64'(busy), 64'd0);

        // start pulsed while receiving is ignored.
        stim_q.delete();
        for (int i = 0; i < 8; i++) stim_q.push_back(8'($urandom_range(0, 255)));
        last_idx = 7;
        run_session(1'b0, 5, -1, e_cyc);
        compare_session("start_mid");

        // Randomized images with random gaps and last positions.
        for (int s = 0; s < 10; s++) begin
            l = $urandom_range(0, 19);
            n = (l + 1 < 17) ? l + 1 : 17;
            stim_q.delete();
            for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom_range(0, 255)));
            last_idx = (l < n) ? l : -1;
            run_session(1'($urandom_range(0, 1)), -1, -1, e_cyc);
            compare_session("random");
        end

        check("ready_low_in_write", 64'(ready_viol), 64'd0);
        check("flags_exclusive",    64'(flag_viol),  64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
